// File: rtl/disp_scanner_pkg.sv
// Shared constants for multiplexed seven-segment display drivers.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
// Contents: blank segment code, active-low hex font (g..a order), index width helper.
package disp_scanner_pkg;

   // All segments off (active-low), dp included.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low hex font, bit 6 = g ... bit 0 = a. Entry F is listed first.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Width of a digit index; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble plus decimal point to active-low seven-segment pattern.
// Latency: purely combinational.
// Backpressure: none.
// Ports: nibble (hex digit), dp (1 = point lit), seg (active-low, seg[7] = dp, seg[6:0] = g..a).
module seg7_hex_decoder
   import disp_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = {~dp, HEX_FONT[nibble]};

endmodule

// File: rtl/disp_scanner.sv
// Multiplexed common-anode digit scanner with PWM brightness and per-frame input snapshot.
// Latency: seg/an/sel/frame_start registered, 1 cycle behind counter/shadow state.
// Backpressure: none; en=0 freezes the scan position and darkens the display.
// Ports: clock, rst (async active-low); en; digits/dp_in/blank (captured once per frame);
//        bright (live PWM code); seg/an (active-low pins); sel (digit index); frame_start (pulse).
module disp_scanner
   import disp_scanner_pkg::*;
#(
   parameter  int NUM_DIGITS = 8,
   parameter  int DIV_LOG2   = 10,
   parameter  int BRIGHT_W   = 3,
   localparam int SEL_W      = sel_width(NUM_DIGITS)
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [SEL_W-1:0]        sel,
   output logic                    frame_start
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

   logic [DIV_LOG2-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    fs_q, fs_d;

   logic                    dwell_end;
   logic                    frame_wrap;
   logic                    lit;
   logic [BRIGHT_W-1:0]     pwm_phase;
   logic [3:0]              cur_nib;
   logic [7:0]              dec_seg;

   // Current digit's shadowed nibble through the shared decoder.
   assign cur_nib = sh_dig_q[{idx_q, 2'b00} +: 4];

   seg7_hex_decoder u_dec (
      .nibble (cur_nib),
      .dp     (sh_dp_q[idx_q]),
      .seg    (dec_seg)
   );

   always_comb begin
      dwell_end  = en & (&cnt_q);
      // Explicit wrap at the last digit so non-power-of-two banks never visit unused indices.
      frame_wrap = dwell_end & (idx_q == LAST_IDX);
      // Top bits of the prescaler form the PWM ramp within each dwell.
      pwm_phase  = cnt_q[DIV_LOG2-1 -: BRIGHT_W];
      lit        = en & ~sh_blank_q[idx_q] & (pwm_phase <= bright);

      cnt_d      = en ? cnt_q + DIV_LOG2'(1) : cnt_q;
      idx_d      = idx_q;
      if (dwell_end) begin
         idx_d = frame_wrap ? '0 : idx_q + SEL_W'(1);
      end

      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      if (frame_wrap) begin
         sh_dig_d   = digits;
         sh_dp_d    = dp_in;
         sh_blank_d = blank;
      end

      seg_d = lit ? dec_seg : SEG_BLANK;
      an_d  = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      sel_d = idx_q;
      fs_d  = frame_wrap;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '1;
         seg_q      <= SEG_BLANK;
         an_q       <= '1;
         sel_q      <= '0;
         fs_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_blank_q <= sh_blank_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         sel_q      <= sel_d;
         fs_q       <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign sel         = sel_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_disp_scanner.sv
// Randomized and directed bench for disp_scanner against a position-counting reference model.
// Latency: model predicts each cycle's registered outputs from the state before the edge.
// Backpressure: n/a.
module tb_disp_scanner;

   localparam int N     = 5;
   localparam int D     = 3;
   localparam int B     = 3;
   localparam int SW    = $clog2(N);
   localparam int DW    = 1 << D;
   localparam int FRAME = N * DW;

   // Active-high hex font (a = bit 0); the display wants the inverse.
   localparam bit [6:0] FONT_HI [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic             clock;
   logic             rst;
   logic             en;
   logic [4*N-1:0]   digits;
   logic [N-1:0]     dp_in;
   logic [N-1:0]     blank;
   logic [B-1:0]     bright;
   logic [7:0]       seg;
   logic [N-1:0]     an;
   logic [SW-1:0]    sel;
   logic             frame_start;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state: enabled-cycle position within the frame plus the shadow copy.
   int             pos;
   logic [4*N-1:0] m_dig;
   logic [N-1:0]   m_dp;
   logic [N-1:0]   m_blank;
   logic [7:0]     exp_seg;
   logic [N-1:0]   exp_an;
   int             exp_sel;
   logic           exp_fs;

   disp_scanner #(.NUM_DIGITS(N), .DIV_LOG2(D), .BRIGHT_W(B)) dut (
      .clock       (clock),
      .rst         (rst),
      .en          (en),
      .digits      (digits),
      .dp_in       (dp_in),
      .blank       (blank),
      .bright      (bright),
      .seg         (seg),
      .an          (an),
      .sel         (sel),
      .frame_start (frame_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      pos     = 0;
      m_dig   = '0;
      m_dp    = '0;
      m_blank = '1;
      exp_seg = 8'hFF;
      exp_an  = '1;
      exp_sel = 0;
      exp_fs  = 1'b0;
   endtask

   // Called at the active edge: outputs follow the pre-edge position, then the position advances.
   task automatic model_step();
      int  digit;
      int  phase;
      bit  on;
      digit   = pos / DW;
      phase   = pos % DW;
      on      = en && !m_blank[digit] && ((phase >> (D - B)) <= int'(bright));
      exp_sel = digit;
      exp_an  = on ? ~(N'(1) << digit) : '1;
      exp_seg = on ? {~m_dp[digit], ~FONT_HI[m_dig[4*digit +: 4]]} : 8'hFF;
      exp_fs  = 1'b0;
      if (en) begin
         pos++;
         if (pos == FRAME) begin
            pos     = 0;
            m_dig   = digits;
            m_dp    = dp_in;
            m_blank = blank;
            exp_fs  = 1'b1;
         end
      end
   endtask

   task automatic compare();
      chk("seg", seg, exp_seg);
      chk("an", an, exp_an);
      chk("sel", sel, exp_sel);
      chk("frame_start", frame_start, exp_fs);
   endtask

   task automatic step();
      @(posedge clock);
      if (rst) model_step();
      @(negedge clock);
      cyc++;
      compare();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before the next edge.
   task automatic mid_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_an", an, {N{1'b1}});
      chk("rst_seg", seg, 8'hFF);
      chk("rst_sel", sel, 0);
      chk("rst_fs", frame_start, 0);
      model_reset();
      @(negedge clock);
      compare();
      rst = 1'b1;
   endtask

   task automatic wait_fs();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * FRAME && !seen; i++) begin
         step();
         if (frame_start === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("fs_timeout", 0, 1);
   endtask

   // Counts lit output cycles over one full frame of steady inputs.
   task automatic lit_count(input string tag, input int exp_lit);
      int n;
      n = 0;
      wait_fs();
      step();
      for (int i = 0; i < FRAME; i++) begin
         if (an !== {N{1'b1}}) n++;
         step();
      end
      chk(tag, n, exp_lit);
   endtask

   initial begin
      int fs_first;
      int fs_second;
      rst    = 1'b0;
      en     = 1'b0;
      digits = '0;
      dp_in  = '0;
      blank  = '0;
      bright = '0;
      model_reset();
      repeat (3) @(negedge clock);
      compare();

      // Full scan with a known pattern; also measure the frame period.
      digits = 20'h310F8;
      dp_in  = 5'b00100;
      blank  = '0;
      bright = 3'd7;
      en     = 1'b1;
      rst    = 1'b1;
      fs_first  = -1;
      fs_second = -1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if (frame_start === 1'b1) begin
            if (fs_first < 0) fs_first = cyc;
            else if (fs_second < 0) fs_second = cyc;
         end
      end
      chk("first_fs", fs_first, FRAME);
      chk("fs_period", fs_second - fs_first, FRAME);

      // Brightness and blanking duty over whole frames.
      bright = 3'd3;
      lit_count("lit_bright3", N * 4);
      bright = 3'd0;
      lit_count("lit_bright0", N);
      bright = 3'd7;
      blank  = 5'b00010;
      lit_count("lit_blank1", (N - 1) * DW);
      blank  = '0;

      // Snapshot: mid-frame digit change must not show until the next frame.
      for (int i = 0; i < FRAME / 2; i++) step();
      digits = 20'hABCDE;
      for (int i = 0; i < 2 * FRAME; i++) step();

      // Pause mid-dwell of digit 2 for 20 cycles.
      for (int i = 0; i < 4 * FRAME && !(pos / DW == 2 && pos % DW == 3); i++) step();
      en = 1'b0;
      for (int i = 0; i < 20; i++) step();
      en = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) step();

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) digits = 20'($urandom);
         if ($urandom_range(0, 15) == 0) dp_in  = 5'($urandom);
         if ($urandom_range(0, 15) == 0) blank  = 5'($urandom) & 5'($urandom);
         if ($urandom_range(0, 31) == 0) bright = 3'($urandom);
         if ($urandom_range(0, 23) == 0) en     = ~en;
         if ($urandom_range(0, 599) == 0) mid_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
